// File: rtl/emif_csr_mb_pkg.sv
// emif_csr_mb_pkg: register map, event-field layout and DFH identity shared by the EMIF CSR block
package emif_csr_mb_pkg;
  localparam int FIELD_W = 16;
  localparam logic [3:0]  DFH_TYPE        = 4'h3;
  localparam logic [11:0] DFH_FEATURE_ID  = 12'h009;
  localparam logic [3:0]  DFH_FEATURE_REV = 4'h1;
  // register offsets expressed as 64-bit word index (byte address bits [11:3])
  localparam logic [8:0] REG_DFH         = 9'h000;
  localparam logic [8:0] REG_STAT        = 9'h001;
  localparam logic [8:0] REG_CTRL        = 9'h002;
  localparam logic [8:0] REG_EVENT       = 9'h003;
  localparam logic [8:0] REG_EVENT_MASK  = 9'h004;
  localparam logic [8:0] REG_CAL_TIMEOUT = 9'h005;
  typedef struct packed {
    logic [FIELD_W-1:0] cal_timeout;
    logic [FIELD_W-1:0] fail_rise;
    logic [FIELD_W-1:0] cal_lost;
  } evt_t;
  function automatic logic [63:0] byte_mask(input logic [7:0] be);
    for (int b = 0; b < 8; b++) byte_mask[b*8 +: 8] = {8{be[b]}};
  endfunction
endpackage

// File: rtl/emif_csr_mb_if.sv
// emif_csr_mb_if: flat CSR request/response bus between the AXI CSR adapter and feature blocks
interface emif_csr_mb_if;
  logic        write;
  logic [19:0] waddr;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        read;
  logic [19:0] raddr;
  logic        read_32b;
  logic [63:0] readdata;
  logic        readdata_valid;
  modport master (output write, waddr, wdata, wstrb, read, raddr, read_32b,
                  input  readdata, readdata_valid);
  modport slave  (input  write, waddr, wdata, wstrb, read, raddr, read_32b,
                  output readdata, readdata_valid);
endinterface

// File: rtl/emif_cal_watchdog.sv
// emif_cal_watchdog: restartable saturating counter that flags banks still uncalibrated at the timeout
module emif_cal_watchdog #(
  parameter int NUM_BANKS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 restart_i,
  input  logic [31:0]          timeout_i,
  input  logic [NUM_BANKS-1:0] success_i,
  input  logic [NUM_BANKS-1:0] failure_i,
  output logic [NUM_BANKS-1:0] fire_o
);
  logic [31:0]          cnt_q, cnt_d;
  logic [NUM_BANKS-1:0] fired_q, fired_d;
  logic                 hit;
  // fired_q stops a saturated counter sitting on the timeout value from refiring
  always_comb begin
    hit     = !restart_i && timeout_i != 32'd0 && cnt_q == timeout_i;
    fire_o  = hit ? ~success_i & ~failure_i & ~fired_q : '0;
    cnt_d   = restart_i ? 32'd0 : (&cnt_q ? cnt_q : cnt_q + 32'd1);
    fired_d = restart_i ? '0 : fired_q | fire_o;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      fired_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      fired_q <= fired_d;
    end
  end
endmodule

// File: rtl/fim_resync.sv
// fim_resync: multi-flop synchroniser for asynchronous level inputs
module fim_resync #(
  parameter int SYNC_CHAIN_LENGTH = 2,
  parameter int WIDTH             = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] sync_q [SYNC_CHAIN_LENGTH];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_CHAIN_LENGTH; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= d_i;
      for (int s = 1; s < SYNC_CHAIN_LENGTH; s++) sync_q[s] <= sync_q[s-1];
    end
  end
  assign q_o = sync_q[SYNC_CHAIN_LENGTH-1];
endmodule

// File: rtl/emif_csr_mb.sv
// emif_csr_mb: EMIF feature CSRs - synchronised calibration status, sticky events, watchdog and interrupt
module emif_csr_mb
  import emif_csr_mb_pkg::*;
#(
  parameter int          NUM_BANKS           = 4,
  parameter logic        END_OF_LIST         = 1'b0,
  parameter logic [23:0] NEXT_DFH_OFFSET     = 24'h05_0000,
  parameter logic [31:0] CAL_TIMEOUT_DEFAULT = 32'd50_000_000,
  parameter int          SYNC_STAGES         = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  emif_csr_mb_if.slave         bus,
  input  logic [NUM_BANKS-1:0] emif_cal_success_i,
  input  logic [NUM_BANKS-1:0] emif_cal_failure_i,
  input  logic [NUM_BANKS-1:0] emif_clear_busy_i,
  output logic [NUM_BANKS-1:0] emif_chkr_clear_n_o,
  output logic                 emif_irq_o
);
  localparam logic [15:0] BANK_M = 16'((32'd1 << NUM_BANKS) - 32'd1);
  localparam logic [47:0] EVT_M  = {3{BANK_M}};
  localparam logic [63:0] DFH    = {DFH_TYPE, 8'h0, 4'h0, 7'h0, END_OF_LIST, NEXT_DFH_OFFSET,
                                    DFH_FEATURE_REV, DFH_FEATURE_ID};
  logic [NUM_BANKS-1:0] succ_s, fail_s, busy_s, tmo_fire;
  logic [NUM_BANKS-1:0] succ_prev_q, fail_prev_q, ctrl_q, ctrl_d;
  evt_t                 evt_q, evt_d, evt_set;
  logic [47:0]          mask_q, mask_d;
  logic [31:0]          tmo_q, tmo_d;
  logic                 irq_q, irq_d, wr_ok, tmo_wr;
  logic [8:0]           wr_idx, rd_idx_q;
  logic [63:0]          wm, wclr, rsel, rdata_d, rdata_q;
  logic                 rd1_q, rd_ok_q, rd32_q, rdhi_q, valid_q;
  logic                 unused_ok;
  fim_resync #(.SYNC_CHAIN_LENGTH(SYNC_STAGES), .WIDTH(3*NUM_BANKS)) u_sync (
    .clk(clk), .rst_n(rst_n),
    .d_i({emif_clear_busy_i, emif_cal_failure_i, emif_cal_success_i}),
    .q_o({busy_s, fail_s, succ_s})
  );
  emif_cal_watchdog #(.NUM_BANKS(NUM_BANKS)) u_wdog (
    .clk(clk), .rst_n(rst_n), .restart_i(tmo_wr), .timeout_i(tmo_q),
    .success_i(succ_s), .failure_i(fail_s), .fire_o(tmo_fire)
  );
  // wclr doubles as the RW write-data term: wdata restricted to enabled byte lanes
  always_comb begin
    wm      = byte_mask(bus.wstrb);
    wclr    = bus.wdata & wm;
    wr_ok   = bus.write && bus.waddr[19:12] == 8'h0;
    wr_idx  = bus.waddr[11:3];
    tmo_wr  = wr_ok && wr_idx == REG_CAL_TIMEOUT;
    evt_set = '0;
    evt_set.cal_lost    = 16'(succ_prev_q & ~succ_s);
    evt_set.fail_rise   = 16'(~fail_prev_q & fail_s);
    evt_set.cal_timeout = 16'(tmo_fire);
    ctrl_d  = wr_ok && wr_idx == REG_CTRL ? ctrl_q & ~wclr[NUM_BANKS-1:0] : ctrl_q;
    evt_d   = (evt_q & ~(wr_ok && wr_idx == REG_EVENT ? wclr[47:0] : 48'h0)) | evt_set;
    mask_d  = wr_ok && wr_idx == REG_EVENT_MASK ? ((mask_q & ~wm[47:0]) | wclr[47:0]) & EVT_M : mask_q;
    tmo_d   = tmo_wr ? (tmo_q & ~wm[31:0]) | wclr[31:0] : tmo_q;
    irq_d   = |(evt_q & mask_q);
    rsel    = !rd_ok_q                      ? 64'h0 :
              rd_idx_q == REG_DFH         ? DFH :
              rd_idx_q == REG_STAT        ? {16'h0, 16'(busy_s), 16'(fail_s), 16'(succ_s)} :
              rd_idx_q == REG_CTRL        ? 64'(ctrl_q) :
              rd_idx_q == REG_EVENT       ? {16'h0, evt_q} :
              rd_idx_q == REG_EVENT_MASK  ? {16'h0, mask_q} :
              rd_idx_q == REG_CAL_TIMEOUT ? {32'h0, tmo_q} : 64'h0;
    rdata_d = !rd32_q ? rsel : rdhi_q ? {rsel[63:32], 32'h0} : {32'h0, rsel[31:0]};
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      succ_prev_q <= '0;
      fail_prev_q <= '0;
      ctrl_q      <= '1;
      evt_q       <= '0;
      mask_q      <= '0;
      tmo_q       <= CAL_TIMEOUT_DEFAULT;
      irq_q       <= 1'b0;
      rd1_q       <= 1'b0;
      rd_ok_q     <= 1'b0;
      rd_idx_q    <= '0;
      rd32_q      <= 1'b0;
      rdhi_q      <= 1'b0;
      valid_q     <= 1'b0;
      rdata_q     <= '0;
    end else begin
      succ_prev_q <= succ_s;
      fail_prev_q <= fail_s;
      ctrl_q      <= ctrl_d;
      evt_q       <= evt_d;
      mask_q      <= mask_d;
      tmo_q       <= tmo_d;
      irq_q       <= irq_d;
      rd1_q       <= bus.read;
      rd_ok_q     <= bus.raddr[19:12] == 8'h0;
      rd_idx_q    <= bus.raddr[11:3];
      rd32_q      <= bus.read_32b;
      rdhi_q      <= bus.raddr[2];
      valid_q     <= rd1_q;
      rdata_q     <= rd1_q ? rdata_d : 64'h0;
    end
  end
  assign unused_ok           = ^{bus.waddr[2:0], bus.raddr[1:0], wclr[63:48]};
  assign bus.readdata        = rdata_q;
  assign bus.readdata_valid  = valid_q;
  assign emif_chkr_clear_n_o = ctrl_q;
  assign emif_irq_o          = irq_q;
endmodule

// File: tb/tb_emif_csr_mb.sv
// tb_emif_csr_mb: directed table-driven and sequence checks of the EMIF CSR block (NUM_BANKS=4)
module tb_emif_csr_mb;
  localparam logic [63:0] DFH_EXP = 64'h3000_0005_0000_1009;
  localparam logic [63:0] TMO_DEF = 64'd50_000_000;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] succ, fail, busy, chkr;
  logic irq;
  logic [63:0] d;
  int n_cmp = 0;
  int n_bad = 0;
  int cyc;
  typedef struct { logic [19:0] addr; logic b32; logic [63:0] exp; } vec_t;
  vec_t tbl[12];
  emif_csr_mb_if bus();
  emif_csr_mb dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .emif_cal_success_i(succ), .emif_cal_failure_i(fail), .emif_clear_busy_i(busy),
    .emif_chkr_clear_n_o(chkr), .emif_irq_o(irq)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic rd(input logic [19:0] a, input logic b32, output logic [63:0] q);
    bus.read = 1'b1; bus.raddr = a; bus.read_32b = b32;
    @(negedge clk);
    bus.read = 1'b0;
    chk("rd_valid_early", 64'(bus.readdata_valid), 64'd0);
    @(negedge clk);
    chk("rd_valid", 64'(bus.readdata_valid), 64'd1);
    q = bus.readdata;
  endtask
  task automatic rdchk(input string name, input logic [19:0] a, input logic b32, input logic [63:0] exp);
    logic [63:0] q;
    rd(a, b32, q);
    chk(name, q, exp);
  endtask
  task automatic wr(input logic [19:0] a, input logic [63:0] dat, input logic [7:0] be);
    bus.write = 1'b1; bus.waddr = a; bus.wdata = dat; bus.wstrb = be;
    @(negedge clk);
    bus.write = 1'b0;
  endtask
  initial begin
    tbl[0]  = '{20'h00000, 1'b0, DFH_EXP};
    tbl[1]  = '{20'h00004, 1'b1, 64'h3000_0005_0000_0000};
    tbl[2]  = '{20'h00000, 1'b1, 64'h0000_0000_0000_1009};
    tbl[3]  = '{20'h00008, 1'b0, 64'h0};
    tbl[4]  = '{20'h00010, 1'b0, 64'hF};
    tbl[5]  = '{20'h00018, 1'b0, 64'h0};
    tbl[6]  = '{20'h00020, 1'b0, 64'h0};
    tbl[7]  = '{20'h00028, 1'b0, TMO_DEF};
    tbl[8]  = '{20'h00028, 1'b1, TMO_DEF};
    tbl[9]  = '{20'h00030, 1'b0, 64'h0};
    tbl[10] = '{20'h001F8, 1'b0, 64'h0};
    tbl[11] = '{20'h01000, 1'b0, 64'h0};
    succ = '0; fail = '0; busy = '0;
    bus.write = 1'b0; bus.waddr = '0; bus.wdata = '0; bus.wstrb = '0;
    bus.read = 1'b0; bus.raddr = '0; bus.read_32b = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 64'(bus.readdata_valid), 64'd0);
    chk("rst_rdata", bus.readdata, 64'h0);
    chk("rst_irq", 64'(irq), 64'd0);
    chk("rst_chkr", 64'(chkr), 64'hF);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 12; i++) rdchk($sformatf("tbl%0d", i), tbl[i].addr, tbl[i].b32, tbl[i].exp);
    // back-to-back reads, one per cycle
    bus.read = 1'b1; bus.read_32b = 1'b0; bus.raddr = 20'h00000;
    @(negedge clk); bus.raddr = 20'h00010;
    @(negedge clk); bus.raddr = 20'h00028;
    chk("b2b_v0", 64'(bus.readdata_valid), 64'd1); chk("b2b_d0", bus.readdata, DFH_EXP);
    @(negedge clk); bus.read = 1'b0;
    chk("b2b_v1", 64'(bus.readdata_valid), 64'd1); chk("b2b_d1", bus.readdata, 64'hF);
    @(negedge clk);
    chk("b2b_v2", 64'(bus.readdata_valid), 64'd1); chk("b2b_d2", bus.readdata, TMO_DEF);
    @(negedge clk);
    chk("b2b_v3", 64'(bus.readdata_valid), 64'd0);
    // status synchronisation and fail_rise
    succ = 4'b1011; fail = 4'b0100;
    repeat (4) @(negedge clk);
    rdchk("stat", 20'h00008, 1'b0, 64'h0000_0004_000B);
    rdchk("stat_hi32", 20'h0000C, 1'b1, 64'h0);
    rdchk("stat_lo32", 20'h00008, 1'b1, 64'h0000_0000_0004_000B);
    rdchk("evt_fail_rise", 20'h00018, 1'b0, 64'h4_0000);
    wr(20'h00018, 64'h4_0000, 8'h04);
    rdchk("evt_w1c", 20'h00018, 1'b0, 64'h0);
    // cal_lost, mask and interrupt
    succ = 4'b1010;
    repeat (4) @(negedge clk);
    rdchk("evt_cal_lost", 20'h00018, 1'b0, 64'h1);
    chk("irq_masked", 64'(irq), 64'd0);
    wr(20'h00018, 64'h1, 8'h02);
    rdchk("evt_wrong_lane", 20'h00018, 1'b0, 64'h1);
    wr(20'h00020, 64'hFFFF_FFFF_FFFF_FFFF, 8'h05);
    rdchk("mask_lanes", 20'h00020, 1'b0, 64'h000F_000F);
    chk("irq_on", 64'(irq), 64'd1);
    wr(20'h00020, 64'h1, 8'hFF);
    rdchk("mask_rw", 20'h00020, 1'b0, 64'h1);
    chk("irq_on2", 64'(irq), 64'd1);
    wr(20'h00018, 64'h1, 8'h01);
    @(negedge clk);
    chk("irq_off", 64'(irq), 64'd0);
    rdchk("evt_cleared", 20'h00018, 1'b0, 64'h0);
    // watchdog: bank 1 idle, others calibrated
    succ = 4'b1101; fail = 4'b0000;
    repeat (5) @(negedge clk);
    wr(20'h00018, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    rdchk("wd_pre_evt", 20'h00018, 1'b0, 64'h0);
    wr(20'h00020, 64'h2_0000_0000, 8'hFF);
    wr(20'h00028, 64'd100, 8'hFF);
    cyc = 1;
    while (!irq && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    n_cmp++;
    if (!(irq && cyc >= 100 && cyc <= 104)) begin
      n_bad++;
      $display("FAIL wd_latency: irq rose %0d cycles after write (irq=%0b), required 100..104", cyc, irq);
    end
    rdchk("wd_evt", 20'h00018, 1'b0, 64'h2_0000_0000);
    wr(20'h00018, 64'h2_0000_0000, 8'h10);
    repeat (30) @(negedge clk);
    rdchk("wd_once", 20'h00018, 1'b0, 64'h0);
    chk("wd_irq_off", 64'(irq), 64'd0);
    wr(20'h00028, 64'd0, 8'hFF);
    repeat (150) @(negedge clk);
    rdchk("wd_disabled", 20'h00018, 1'b0, 64'h0);
    rdchk("wd_tmo0", 20'h00028, 1'b0, 64'h0);
    // hardware set wins over same-cycle W1C
    fail = 4'b0100;
    repeat (3) @(negedge clk);
    wr(20'h00018, 64'h4_0000, 8'h04);
    rdchk("evt_precedence", 20'h00018, 1'b0, 64'h4_0000);
    // byte-lane RW with a read in the cycle right after the write
    wr(20'h00028, 64'hAABB_CCDD, 8'h05);
    rdchk("tmo_lanes", 20'h00028, 1'b0, 64'h00BB_00DD);
    // CTRL W1C and unmapped writes
    wr(20'h00010, 64'hF, 8'h00);
    chk("chkr_nostrb", 64'(chkr), 64'hF);
    wr(20'h00010, 64'h5, 8'h01);
    chk("chkr_w1c", 64'(chkr), 64'hA);
    rdchk("ctrl_rd", 20'h00010, 1'b0, 64'hA);
    wr(20'h00030, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    rdchk("unmapped_wr", 20'h00030, 1'b0, 64'h0);
    // reset during a read drops it
    bus.read = 1'b1; bus.raddr = 20'h00000; bus.read_32b = 1'b0;
    @(negedge clk); bus.read = 1'b0; rst_n = 1'b0;
    @(negedge clk); chk("rstrd_v0", 64'(bus.readdata_valid), 64'd0);
    @(negedge clk); chk("rstrd_v1", 64'(bus.readdata_valid), 64'd0); rst_n = 1'b1;
    @(negedge clk); chk("rstrd_v2", 64'(bus.readdata_valid), 64'd0);
    chk("rst2_chkr", 64'(chkr), 64'hF);
    chk("rst2_irq", 64'(irq), 64'd0);
    repeat (5) @(negedge clk);
    rdchk("rst2_fail_high", 20'h00018, 1'b0, 64'h4_0000);
    rdchk("rst2_tmo", 20'h00028, 1'b0, TMO_DEF);
    rdchk("rst2_mask", 20'h00020, 1'b0, 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
